// File: rtl/enemy_bullet_pool.sv
// enemy_bullet_pool: fixed pool of downward enemy bullets with fire, motion, player-hit detection and pixel output.
module enemy_bullet_pool #(
  parameter int NUM_SLOTS = 4,
  parameter int SPEED     = 2,
  parameter int B_W       = 6,
  parameter int B_H       = 12,
  parameter int P_W       = 46,
  parameter int P_H       = 40,
  parameter int Y_LIMIT   = 480
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               move_tick,
  input  logic                               boom,
  input  logic                               fire_req,
  input  logic [9:0]                         fire_x,
  input  logic [9:0]                         fire_y,
  output logic                               fire_ack,
  output logic                               fire_drop,
  input  logic [9:0]                         p_x,
  input  logic [9:0]                         p_y,
  input  logic [9:0]                         x,
  input  logic [9:0]                         y,
  output logic                               ebullet_en,
  output logic [11:0]                        ebullet_rgb,
  output logic                               player_hit,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     active_cnt
);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [10:0] YL = 11'(Y_LIMIT);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] BW = 11'(B_W);
  localparam logic [10:0] BH = 11'(B_H);
  localparam logic [10:0] PW = 11'(P_W);
  localparam logic [10:0] PH = 11'(P_H);
  logic [NUM_SLOTS-1:0]       valid_q, valid_d;
  logic [NUM_SLOTS-1:0][9:0]  bx_q, bx_d, by_q, by_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       ack_q, drop_q, hit_q, hit_d, fire_ok, found, en;
  logic [10:0]                ny, bx_e, px_e, py_e, xx, yy;
  assign px_e = {1'b0, p_x};
  assign py_e = {1'b0, p_y};
  assign xx   = {1'b0, x};
  assign yy   = {1'b0, y};
  // Fire only sees slots free at cycle start, so a slot vacated this cycle waits one cycle.
  always_comb begin
    valid_d = valid_q;
    bx_d    = bx_q;
    by_d    = by_q;
    hit_d   = 1'b0;
    found   = 1'b0;
    ny      = '0;
    bx_e    = '0;
    cnt_d   = '0;
    fire_ok = fire_req && !boom && ({1'b0, fire_y} < YL) && !(&valid_q);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ny   = {1'b0, by_q[i]} + SP;
      bx_e = {1'b0, bx_q[i]};
      if (boom) valid_d[i] = 1'b0;
      else if (move_tick && valid_q[i]) begin
        if (ny >= YL) valid_d[i] = 1'b0;
        else if (bx_e < px_e + PW && bx_e + BW > px_e && ny < py_e + PH && ny + BH > py_e) begin
          valid_d[i] = 1'b0;
          hit_d      = 1'b1;
        end else by_d[i] = ny[9:0];
      end
      if (fire_ok && !valid_q[i] && !found) begin
        found      = 1'b1;
        valid_d[i] = 1'b1;
        bx_d[i]    = fire_x;
        by_d[i]    = fire_y;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) cnt_d = cnt_d + CW'(valid_d[i]);
  end
  always_comb begin
    en = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      en = en | (valid_q[i] && xx >= {1'b0, bx_q[i]} && xx < {1'b0, bx_q[i]} + BW &&
                 yy >= {1'b0, by_q[i]} && yy < {1'b0, by_q[i]} + BH);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cnt_q   <= cnt_d;
      ack_q   <= fire_ok;
      drop_q  <= fire_req && !fire_ok;
      hit_q   <= hit_d;
    end
  end
  assign fire_ack    = ack_q;
  assign fire_drop   = drop_q;
  assign player_hit  = hit_q;
  assign active_cnt  = cnt_q;
  assign ebullet_en  = en;
  assign ebullet_rgb = en ? 12'hF00 : 12'h000;
endmodule

// File: tb/tb_enemy_bullet_pool.sv
// tb_enemy_bullet_pool: scoreboard bench; driver steps a bullet-list model, monitor checks DUT outputs each cycle.
module tb_enemy_bullet_pool;
  logic       clk = 1'b0, rst = 1'b0, move_tick = 1'b0, boom = 1'b0, fire_req = 1'b0;
  logic [9:0] fire_x = '0, fire_y = '0, p_x = '0, p_y = '0, x = '0, y = '0;
  logic       fire_ack, fire_drop, ebullet_en, player_hit;
  logic [11:0] ebullet_rgb;
  logic [2:0] active_cnt;
  enemy_bullet_pool dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .boom(boom), .fire_req(fire_req),
    .fire_x(fire_x), .fire_y(fire_y), .fire_ack(fire_ack), .fire_drop(fire_drop),
    .p_x(p_x), .p_y(p_y), .x(x), .y(y), .ebullet_en(ebullet_en), .ebullet_rgb(ebullet_rgb),
    .player_hit(player_hit), .active_cnt(active_cnt)
  );
  always #5 clk = ~clk;
  typedef struct { bit v; int bx; int by; } blt_t;
  typedef struct { bit ack; bit drop; bit hit; int cnt; bit en; } exp_t;
  blt_t m[4];
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int ppx = 600, ppy = 0;
  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction
  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m[i] = '{0, 0, 0};
  endfunction
  function automatic bit on_bullet(int sx, int sy);
    bit r = 0;
    for (int i = 0; i < 4; i++)
      if (m[i].v && sx >= m[i].bx && sx < m[i].bx + 6 && sy >= m[i].by && sy < m[i].by + 12) r = 1;
    return r;
  endfunction
  task automatic cyc(input bit fr, input int fx, input int fy, input bit mt, input bit bm, input int sx, input int sy);
    exp_t e;
    int fxi, fyi, pxi, pyi, free, ny;
    @(negedge clk);
    fire_req = fr; fire_x = 10'(fx); fire_y = 10'(fy); move_tick = mt; boom = bm;
    x = 10'(sx); y = 10'(sy); p_x = 10'(ppx); p_y = 10'(ppy);
    fxi = int'(fire_x); fyi = int'(fire_y); pxi = int'(p_x); pyi = int'(p_y);
    e = '{0, 0, 0, 0, 0};
    free = -1;
    for (int i = 3; i >= 0; i--) if (!m[i].v) free = i;
    if (bm) begin
      model_clear();
      e.drop = fr;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m[i].v && mt) begin
          ny = m[i].by + 2;
          if (ny >= 480) m[i].v = 0;
          else if (m[i].bx < pxi + 46 && m[i].bx + 6 > pxi && ny < pyi + 40 && ny + 12 > pyi) begin
            m[i].v = 0;
            e.hit = 1;
          end else m[i].by = ny;
        end
      end
      if (fr && fyi < 480 && free >= 0) begin
        m[free] = '{1, fxi, fyi};
        e.ack = 1;
      end else e.drop = fr;
    end
    for (int i = 0; i < 4; i++) e.cnt += int'(m[i].v);
    e.en = on_bullet(int'(x), int'(y));
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1023, 1023);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 1023, 1023);
  endtask
  task automatic rst_check(string tag);
    chk({tag, " fire_ack"}, int'(fire_ack), 0);
    chk({tag, " fire_drop"}, int'(fire_drop), 0);
    chk({tag, " player_hit"}, int'(player_hit), 0);
    chk({tag, " active_cnt"}, int'(active_cnt), 0);
    chk({tag, " ebullet_en"}, int'(ebullet_en), 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fire_ack", int'(fire_ack), int'(e.ack));
        chk("fire_drop", int'(fire_drop), int'(e.drop));
        chk("player_hit", int'(player_hit), int'(e.hit));
        chk("active_cnt", int'(active_cnt), e.cnt);
        chk("ebullet_en", int'(ebullet_en), int'(e.en));
        chk("ebullet_rgb", int'(ebullet_rgb), e.en ? 12'hF00 : 0);
      end
    end
  end
  initial begin
    int k, sx, sy, fx;
    #2 rst = 1'b1;
    #1 rst_check("reset");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    // single bullet travels 10 steps, then pixel checks inside and just outside
    cyc(1, 100, 50, 0, 0, 100, 50);
    ticks(9);
    cyc(0, 0, 0, 1, 0, 102, 75);
    cyc(0, 0, 0, 0, 0, 106, 75);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 200 + 20 * i, 100, 0, 0, 200 + 20 * i, 100);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // retire at the screen bottom
    cyc(1, 100, 466, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 101, 470 + 2 * i);
    cyc(1, 300, 479, 0, 0, 0, 0);
    cyc(1, 300, 480, 0, 0, 0, 0);
    ticks(2);
    // player hits, single and simultaneous
    ppx = 90; ppy = 300;
    cyc(1, 100, 278, 0, 0, 0, 0);
    ticks(8);
    cyc(1, 100, 280, 0, 0, 0, 0);
    cyc(1, 120, 280, 0, 0, 0, 0);
    ticks(6);
    // fire and move in the same cycle
    ppx = 600; ppy = 0;
    cyc(1, 300, 100, 0, 0, 0, 0);
    cyc(1, 400, 200, 1, 0, 300, 102);
    cyc(0, 0, 0, 0, 0, 400, 200);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // boom with concurrent fire
    for (int i = 0; i < 3; i++) cyc(1, 50 * i, 60, 0, 0, 0, 0);
    cyc(1, 500, 60, 0, 1, 0, 60);
    idle(2);
    // full pool with a retire in the same cycle: freed slot not reused yet
    for (int i = 0; i < 4; i++) cyc(1, 40 * i, 478 - (i == 0 ? 0 : 100), 0, 0, 0, 0);
    cyc(1, 700, 10, 1, 0, 0, 0);
    cyc(1, 700, 10, 0, 0, 702, 12);
    // asynchronous reset mid-flight
    cyc(1, 10, 10, 1, 0, 12, 12);
    @(negedge clk);
    fire_req = 0; move_tick = 0; boom = 0; x = 12; y = 12;
    rst = 1'b1;
    #1 rst_check("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cyc(1, 10, 10, 0, 0, 12, 12);
    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        ppx = $urandom_range(0, 900);
        ppy = $urandom_range(150, 460);
      end
      k = $urandom_range(0, 3);
      if (m[k].v && $urandom_range(0, 3) != 0) begin
        sx = m[k].bx + $urandom_range(0, 7) - 1;
        sy = m[k].by + $urandom_range(0, 15) - 1;
      end else begin
        sx = $urandom_range(0, 1023);
        sy = $urandom_range(0, 1023);
      end
      fx = $urandom_range(0, 1) ? ppx + $urandom_range(0, 60) - 10 : $urandom_range(0, 1023);
      if (fx < 0) fx = 0;
      cyc($urandom_range(0, 9) < 3, fx, $urandom_range(0, 520), $urandom_range(0, 1),
          $urandom_range(0, 49) == 0, sx, sy);
    end
    idle(3);
    @(negedge clk);
    if (q.size() != 0) chk("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
